shift_exec_stage: RTL and testbench

Two-stage pipelined shift/rotate execution unit for the 16-bit processor. It accepts decoded shift micro-ops from issue with a valid/ready handshake and registers the operands. It drives the existing `leftshifter16bit` and `rightshifter16bit` barrel shifters, then registers the result and Z/N/C flags. Writeback consumes that registered result through a second valid/ready handshake.

---
 rtl/shift_pkg.sv | 26 ++
 rtl/leftshifter16bit.sv | 20 ++
 rtl/rightshifter16bit.sv | 20 ++
 rtl/shift_exec_stage_datapath.sv | 67 ++++++
 rtl/shift_exec_stage.sv | 108 ++++++++++
 tb/tb_shift_exec_stage.sv | 293 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared opcodes, widths and stage occupancy type for the shift execution unit
package shift_pkg;

    localparam int DATA_W = 16;
    localparam int MAG_W  = 4;
    localparam int TAG_W  = 3;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_LSL = 3'b000;
    localparam logic [OP_W-1:0] OP_LSR = 3'b001;
    localparam logic [OP_W-1:0] OP_ASR = 3'b010;
    localparam logic [OP_W-1:0] OP_ROL = 3'b011;
    localparam logic [OP_W-1:0] OP_ROR = 3'b100;

    // Occupancy of one pipeline stage
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } occ_t;

    // Opcodes above ROR are reserved and pass the operand through
    function automatic logic is_reserved(input logic [OP_W-1:0] op);
        return op > OP_ROR;
    endfunction

endpackage

// File: rtl/leftshifter16bit.sv
// rtl/leftshifter16bit.sv - 16-bit logarithmic left barrel shifter, zero fill
module leftshifter16bit (
    input  logic [15:0] in,
    input  logic [3:0]  shamt,
    output logic [15:0] out
);

    logic [15:0] st1;
    logic [15:0] st2;
    logic [15:0] st4;

    // Four binary-weighted stages: 1, 2, 4, 8
    always_comb begin
        st1 = shamt[0] ? {in[14:0],  1'b0}  : in;
        st2 = shamt[1] ? {st1[13:0], 2'b0}  : st1;
        st4 = shamt[2] ? {st2[11:0], 4'b0}  : st2;
        out = shamt[3] ? {st4[7:0],  8'b0}  : st4;
    end

endmodule

// File: rtl/rightshifter16bit.sv
// rtl/rightshifter16bit.sv - 16-bit logarithmic right barrel shifter, zero fill
module rightshifter16bit (
    input  logic [15:0] in,
    input  logic [3:0]  shamt,
    output logic [15:0] out
);

    logic [15:0] st1;
    logic [15:0] st2;
    logic [15:0] st4;

    // Four binary-weighted stages: 1, 2, 4, 8
    always_comb begin
        st1 = shamt[0] ? {1'b0, in[15:1]}  : in;
        st2 = shamt[1] ? {2'b0, st1[15:2]} : st1;
        st4 = shamt[2] ? {4'b0, st2[15:4]} : st2;
        out = shamt[3] ? {8'b0, st4[15:8]} : st4;
    end

endmodule

// File: rtl/shift_exec_stage_datapath.sv
// rtl/shift_exec_stage_datapath.sv - combinational shift/rotate result, carry and reserved-op detect
module shift_datapath
    import shift_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [MAG_W-1:0]  mag,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              err
);

    // (16 - n) truncated to 4 bits; n=0 wraps to 0, which rotates handle explicitly
    logic [MAG_W-1:0]  inv_mag;
    logic [MAG_W-1:0]  mag_m1;
    logic [DATA_W-1:0] l_n;
    logic [DATA_W-1:0] l_inv;
    logic [DATA_W-1:0] r_n;
    logic [DATA_W-1:0] r_inv;
    logic [DATA_W-1:0] r_ones;
    logic              nz;

    assign inv_mag = 4'd0 - mag;
    assign mag_m1  = mag - 4'd1;
    assign nz      = (mag != 4'd0);

    leftshifter16bit  u_lsl_n   (.in(a),       .shamt(mag),     .out(l_n));
    leftshifter16bit  u_lsl_inv (.in(a),       .shamt(inv_mag), .out(l_inv));
    rightshifter16bit u_lsr_n   (.in(a),       .shamt(mag),     .out(r_n));
    rightshifter16bit u_lsr_inv (.in(a),       .shamt(inv_mag), .out(r_inv));
    rightshifter16bit u_mask    (.in(16'hFFFF), .shamt(mag),    .out(r_ones));

    // Select result per opcode; carry is the last bit shifted out and is 0 when n=0
    always_comb begin
        result = a;
        carry  = 1'b0;
        err    = 1'b0;
        case (op)
            OP_LSL: begin
                result = l_n;
                carry  = nz & a[inv_mag];
            end
            OP_LSR: begin
                result = r_n;
                carry  = nz & a[mag_m1];
            end
            OP_ASR: begin
                result = r_n | (a[DATA_W-1] ? ~r_ones : '0);
                carry  = nz & a[mag_m1];
            end
            OP_ROL: begin
                result = nz ? (l_n | r_inv) : a;
                carry  = nz & result[0];
            end
            OP_ROR: begin
                result = nz ? (r_n | l_inv) : a;
                carry  = nz & result[DATA_W-1];
            end
            default: begin
                result = a;
                carry  = 1'b0;
                err    = is_reserved(op);
            end
        endcase
    end

endmodule

// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - two-stage pipelined shift/rotate unit with valid/ready on both sides
module shift_exec_stage
    import shift_pkg::*;
#(
    parameter int TAG_W = shift_pkg::TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [MAG_W-1:0]  in_mag,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_z,
    output logic              out_n,
    output logic              out_c,
    output logic              out_err
);

    occ_t              s1_state;
    occ_t              s2_state;
    logic              s1_valid;
    logic              s2_valid;
    logic              s2_adv;
    logic              s1_load;
    logic              s2_load;

    logic [OP_W-1:0]   s1_op;
    logic [DATA_W-1:0] s1_a;
    logic [MAG_W-1:0]  s1_mag;
    logic [TAG_W-1:0]  s1_tag;

    logic [DATA_W-1:0] dp_result;
    logic              dp_carry;
    logic              dp_err;

    assign s1_valid  = (s1_state == ST_FULL);
    assign s2_valid  = (s2_state == ST_FULL);
    assign out_valid = s2_valid;

    // S2 can take new data when empty or draining; S1 likewise when S2 moves
    assign s2_adv   = !s2_valid | out_ready;
    assign in_ready = !s1_valid | s2_adv;
    assign s1_load  = in_valid & in_ready;
    assign s2_load  = s1_valid & s2_adv;

    shift_datapath u_dp (
        .op     (s1_op),
        .a      (s1_a),
        .mag    (s1_mag),
        .result (dp_result),
        .carry  (dp_carry),
        .err    (dp_err)
    );

    // Stage 1 occupancy and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_state <= ST_EMPTY;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_mag   <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_state <= ST_EMPTY;
        end else if (s1_load) begin
            s1_state <= ST_FULL;
            s1_op    <= in_op;
            s1_a     <= in_a;
            s1_mag   <= in_mag;
            s1_tag   <= in_tag;
        end else if (s2_load) begin
            s1_state <= ST_EMPTY;
        end
    end

    // Stage 2 occupancy and registered result/flags; held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_state   <= ST_EMPTY;
            out_result <= '0;
            out_tag    <= '0;
            out_z      <= 1'b0;
            out_n      <= 1'b0;
            out_c      <= 1'b0;
            out_err    <= 1'b0;
        end else if (flush) begin
            s2_state <= ST_EMPTY;
        end else if (s2_load) begin
            s2_state   <= ST_FULL;
            out_result <= dp_result;
            out_tag    <= s1_tag;
            out_z      <= (dp_result == '0);
            out_n      <= dp_result[DATA_W-1];
            out_c      <= dp_carry;
            out_err    <= dp_err;
        end else if (s2_valid & out_ready) begin
            s2_state <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - scoreboard bench for shift_exec_stage
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [15:0] in_a = '0;
    logic [3:0]  in_mag = '0;
    logic [2:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [2:0]  out_tag;
    logic        out_z, out_n, out_c, out_err;

    shift_exec_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_mag(in_mag), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [3:0]  mag;
        logic [2:0]  tag;
        logic [15:0] res;
        logic        c;
        logic        err;
    } vec_t;

    typedef struct {
        logic [22:0] exp;
        bit          lat;
        int          due;
    } sb_t;

    sb_t sbq[$];

    int or_mode = 0;
    int or_ph = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) begin
        #2;
        case (or_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (or_ph == 0);
                or_ph = (or_ph + 1) % 3;
            end
            default: out_ready = 1'b0;
        endcase
    end

    function automatic vec_t mk(input logic [2:0] op, input logic [15:0] a, input logic [3:0] mag,
                                input logic [2:0] tag, input logic [15:0] res, input logic c,
                                input logic err);
        vec_t v;
        v.op = op; v.a = a; v.mag = mag; v.tag = tag; v.res = res; v.c = c; v.err = err;
        return v;
    endfunction

    task automatic send(input vec_t v, input bit lat);
        sb_t e;
        int c;
        bit ok;
        in_valid = 1'b1;
        in_op = v.op; in_a = v.a; in_mag = v.mag; in_tag = v.tag;
        ok = 1'b0;
        c = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                c = cyc;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout tag=%0d: in_ready stayed 0, required 1 within 50 cycles", v.tag);
        end
        @(posedge clk);
        if (ok) begin
            e.exp = {v.tag, v.res, (v.res == 16'h0), v.res[15], v.c, v.err};
            e.lat = lat;
            e.due = c + 2;
            sbq.push_back(e);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 60) begin
            @(posedge clk);
            k++;
        end
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [24:0] act;
        act = {out_valid, out_result, out_tag, out_z, out_n, out_c, out_err, in_ready};
        checks++;
        if (act !== {1'b0, 16'h0, 3'h0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL %s: outputs {valid,result,tag,z,n,c,err,in_ready}=%h, required %h",
                     name, act, {1'b0, 16'h0, 3'h0, 4'h0, 1'b1});
        end
    endtask

    // Monitor: in_ready rule, stall stability, in-order result compare and latency
    logic [22:0] snap;
    bit          held = 1'b0;
    always @(negedge clk) begin
        logic [22:0] cur;
        logic        exp_ir;
        sb_t         e;
        cur = {out_tag, out_result, out_z, out_n, out_c, out_err};
        if (!rst_n || flush || !mon_en) begin
            held = 1'b0;
        end else begin
            exp_ir = !(sbq.size() == 2 && !out_ready);
            checks++;
            if (in_ready !== exp_ir) begin
                errors++;
                $display("FAIL in_ready cyc=%0d: got %b, required %b (in flight %0d, out_ready %b)",
                         cyc, in_ready, exp_ir, sbq.size(), out_ready);
            end
            if (held) begin
                checks++;
                if ({out_valid, cur} !== {1'b1, snap}) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d: got valid=%b out=%h, required valid=1 out=%h",
                             cyc, out_valid, cur, snap);
                end
            end
            held = 1'b0;
            if (out_valid && !out_ready) begin
                held = 1'b1;
                snap = cur;
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output cyc=%0d: got out=%h with nothing outstanding", cyc, cur);
                end else begin
                    e = sbq.pop_front();
                    checks++;
                    if (cur !== e.exp) begin
                        errors++;
                        $display("FAIL result tag=%0d: got {tag,result,z,n,c,err}=%h, required %h",
                                 e.exp[22:20], cur, e.exp);
                    end
                    if (e.lat) begin
                        checks++;
                        if (cyc != e.due) begin
                            errors++;
                            $display("FAIL latency tag=%0d: got cycle %0d, required %0d",
                                     e.exp[22:20], cyc, e.due);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("after_reset_release");
        mon_en = 1'b1;
        idle(1);

        // Directed vectors, out_ready held high, latency checked
        or_mode = 0;
        send(mk(3'b000, 16'h0001, 4'd4,  3'd1, 16'h0010, 1'b0, 1'b0), 1'b1);
        send(mk(3'b000, 16'h8000, 4'd1,  3'd2, 16'h0000, 1'b1, 1'b0), 1'b1);
        send(mk(3'b001, 16'h8001, 4'd1,  3'd3, 16'h4000, 1'b1, 1'b0), 1'b1);
        send(mk(3'b010, 16'h8000, 4'd15, 3'd4, 16'hFFFF, 1'b0, 1'b0), 1'b1);
        send(mk(3'b010, 16'h7FFF, 4'd3,  3'd5, 16'h0FFF, 1'b1, 1'b0), 1'b1);
        send(mk(3'b011, 16'h8001, 4'd1,  3'd6, 16'h0003, 1'b1, 1'b0), 1'b1);
        send(mk(3'b100, 16'h0001, 4'd4,  3'd7, 16'h1000, 1'b0, 1'b0), 1'b1);
        send(mk(3'b100, 16'h0003, 4'd1,  3'd0, 16'h8001, 1'b1, 1'b0), 1'b1);
        send(mk(3'b001, 16'h8000, 4'd15, 3'd1, 16'h0001, 1'b0, 1'b0), 1'b1);
        send(mk(3'b000, 16'h0001, 4'd15, 3'd2, 16'h8000, 1'b0, 1'b0), 1'b1);
        for (int op = 0; op < 5; op++)
            send(mk(3'(op), 16'hA5A5, 4'd0, 3'(op), 16'hA5A5, 1'b0, 1'b0), 1'b1);
        send(mk(3'b110, 16'h1234, 4'd5,  3'd5, 16'h1234, 1'b0, 1'b1), 1'b1);
        drain();

        // Back-to-back stream with out_ready toggling 1,0,0
        or_mode = 1;
        or_ph = 0;
        idle(1);
        send(mk(3'b000, 16'h00FF, 4'd8,  3'd0, 16'hFF00, 1'b0, 1'b0), 1'b0);
        send(mk(3'b001, 16'h00FF, 4'd4,  3'd1, 16'h000F, 1'b1, 1'b0), 1'b0);
        send(mk(3'b010, 16'hF000, 4'd4,  3'd2, 16'hFF00, 1'b0, 1'b0), 1'b0);
        send(mk(3'b011, 16'h1234, 4'd4,  3'd3, 16'h2341, 1'b1, 1'b0), 1'b0);
        send(mk(3'b100, 16'h1234, 4'd4,  3'd4, 16'h4123, 1'b0, 1'b0), 1'b0);
        send(mk(3'b000, 16'hFFFF, 4'd15, 3'd5, 16'h8000, 1'b1, 1'b0), 1'b0);
        send(mk(3'b100, 16'h8000, 4'd15, 3'd6, 16'h0001, 1'b0, 1'b0), 1'b0);
        send(mk(3'b111, 16'h0000, 4'd9,  3'd7, 16'h0000, 1'b0, 1'b1), 1'b0);
        drain();

        // Flush with both stages full and a concurrent offer
        or_mode = 2;
        idle(1);
        send(mk(3'b000, 16'h0101, 4'd1, 3'd5, 16'h0202, 1'b0, 1'b0), 1'b0);
        send(mk(3'b001, 16'h0101, 4'd1, 3'd6, 16'h0080, 1'b1, 1'b0), 1'b0);
        idle(1);
        flush = 1'b1;
        in_valid = 1'b1;
        in_op = 3'b000; in_a = 16'h0F0F; in_mag = 4'd2; in_tag = 3'd3;
        @(posedge clk);
        sbq.delete();
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clears: out_valid=%b, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        or_mode = 0;
        idle(6);

        // Asynchronous reset mid-stream
        send(mk(3'b011, 16'h4000, 4'd2, 3'd1, 16'h0001, 1'b1, 1'b0), 1'b0);
        send(mk(3'b001, 16'hFFFF, 4'd8, 3'd2, 16'h00FF, 1'b1, 1'b0), 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset_midstream");
        sbq.delete();
        @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send(mk(3'b010, 16'hC000, 4'd1, 3'd4, 16'hE000, 1'b0, 1'b0), 1'b1);
        drain();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
